// File: rtl/icache_ctrl.sv
// ============================================================================
//  Module      : icache_ctrl
//  Description : Direct-mapped instruction cache sitting between the CPU PC
//                and a slow block-oriented instruction memory. Hits return
//                the instruction in the same cycle; misses fetch a whole
//                128-bit block through a read/busywait handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module icache_ctrl #(
    parameter int NUM_BLOCKS = 8,
    parameter int ADDR_W     = 10
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [31:0]         address,
    output logic [31:0]         instruction,
    output logic                busywait,
    output logic                mem_read,
    output logic [ADDR_W-5:0]   mem_address,
    input  logic [127:0]        mem_readdata,
    input  logic                mem_busywait
);

    localparam int IDX_W = $clog2(NUM_BLOCKS);
    localparam int BLK_W = ADDR_W - 4;
    localparam int TAG_W = BLK_W - IDX_W;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_MEM_READ = 2'd1,
        S_UPDATE   = 2'd2
    } state_t;

    state_t                 state_q, state_d;

    // Block address (tag + index) latched when the miss is detected, so the
    // refill lands where the miss was seen even if the PC moves meanwhile.
    logic [BLK_W-1:0]       blk_q;
    logic [127:0]           stage_q;

    logic [NUM_BLOCKS-1:0]  valid_q;
    logic [TAG_W-1:0]       tag_q  [NUM_BLOCKS];
    logic [127:0]           data_q [NUM_BLOCKS];

    // Decode of the current fetch address
    logic [BLK_W-1:0]       cur_blk;
    logic [IDX_W-1:0]       cur_idx;
    logic [TAG_W-1:0]       cur_tag;
    logic [1:0]             cur_off;
    logic                   hit;
    logic [31:0]            hit_word;

    logic                   latch_en;
    logic                   capture_en;
    logic                   fill_en;

    logic [IDX_W-1:0]       fill_idx;
    logic [TAG_W-1:0]       fill_tag;

    // Bits outside the decoded window alias and are deliberately dropped
    logic                   unused_addr_bits;
    assign unused_addr_bits = ^{address[31:ADDR_W], address[1:0]};

    assign cur_blk  = address[ADDR_W-1:4];
    assign cur_idx  = cur_blk[IDX_W-1:0];
    assign cur_tag  = cur_blk[BLK_W-1:IDX_W];
    assign cur_off  = address[3:2];
    assign fill_idx = blk_q[IDX_W-1:0];
    assign fill_tag = blk_q[BLK_W-1:IDX_W];

    // Tag compare and word select for the current PC
    always_comb begin
        hit      = valid_q[cur_idx] && (tag_q[cur_idx] == cur_tag);
        hit_word = data_q[cur_idx][{cur_off, 5'd0} +: 32];
    end

    // Next-state and output decode; reset forces quiet outputs and blocks
    // any pending latch/capture/fill from taking effect on the reset edge.
    always_comb begin
        state_d     = state_q;
        busywait    = 1'b0;
        instruction = 32'd0;
        mem_read    = 1'b0;
        mem_address = '0;
        latch_en    = 1'b0;
        capture_en  = 1'b0;
        fill_en     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (hit) begin
                    instruction = hit_word;
                end else begin
                    busywait = 1'b1;
                    latch_en = 1'b1;
                    state_d  = S_MEM_READ;
                end
            end
            S_MEM_READ: begin
                busywait    = 1'b1;
                mem_read    = 1'b1;
                mem_address = blk_q;
                if (!mem_busywait) begin
                    capture_en = 1'b1;
                    state_d    = S_UPDATE;
                end
            end
            S_UPDATE: begin
                busywait = 1'b1;
                fill_en  = 1'b1;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (reset) begin
            busywait    = 1'b0;
            instruction = 32'd0;
            latch_en    = 1'b0;
            capture_en  = 1'b0;
            fill_en     = 1'b0;
        end
    end

    // Control state: FSM, latched miss address, staging buffer, valid bits
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            blk_q   <= '0;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            if (latch_en) begin
                blk_q <= cur_blk;
            end
            if (fill_en) begin
                valid_q[fill_idx] <= 1'b1;
            end
        end
    end

    // Staging register holds the block returned by memory until UPDATE
    always_ff @(posedge clk) begin
        if (capture_en) begin
            stage_q <= mem_readdata;
        end
    end

    // Tag and data arrays: written only on the UPDATE edge, no reset needed
    // because the valid bits gate every use of them.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_q[fill_idx]  <= fill_tag;
            data_q[fill_idx] <= stage_q;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_icache_ctrl.sv
// ============================================================================
//  Module      : tb_icache_ctrl
//  Description : Self-checking bench for icache_ctrl. A memory responder with
//                programmable latency serves blocks whose words equal their
//                word address; a lookup-table cache model predicts hit/miss.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_icache_ctrl;

    logic           clk = 1'b0;
    logic           reset;
    logic [31:0]    address;
    logic [31:0]    instruction;
    logic           busywait;
    logic           mem_read;
    logic [5:0]     mem_address;
    logic [127:0]   mem_readdata;
    logic           mem_busywait;

    int n_vec = 0;
    int n_err = 0;
    int mem_lat = 0;
    int mem_cnt = 0;

    // Reference cache state: which tag each line holds
    bit         ref_valid [8];
    logic [2:0] ref_tag   [8];

    icache_ctrl #(
        .NUM_BLOCKS (8),
        .ADDR_W     (10)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .address      (address),
        .instruction  (instruction),
        .busywait     (busywait),
        .mem_read     (mem_read),
        .mem_address  (mem_address),
        .mem_readdata (mem_readdata),
        .mem_busywait (mem_busywait)
    );

    always #5 clk = ~clk;

    // Instruction memory: word k of block b holds the word address {b,k}
    function automatic logic [127:0] blk_data(input logic [5:0] b);
        logic [127:0] d;
        for (int i = 0; i < 4; i++) begin
            d[i*32 +: 32] = {24'h0, b, 2'(i)};
        end
        return d;
    endfunction

    // Memory responder: busy for mem_lat cycles, then data for one cycle
    always @(negedge clk) begin
        if (mem_read) begin
            if (mem_cnt < mem_lat) begin
                mem_busywait = 1'b1;
                mem_readdata = {$urandom, $urandom, $urandom, $urandom};
                mem_cnt      = mem_cnt + 1;
            end else begin
                mem_busywait = 1'b0;
                mem_readdata = blk_data(mem_address);
            end
        end else begin
            mem_cnt      = 0;
            mem_busywait = 1'b0;
            mem_readdata = {$urandom, $urandom, $urandom, $urandom};
        end
    end

    task automatic model_clear();
        for (int i = 0; i < 8; i++) begin
            ref_valid[i] = 1'b0;
            ref_tag[i]   = 3'd0;
        end
    endtask

    task automatic model_access(input logic [31:0] a, output bit hit);
        logic [2:0] idx;
        logic [2:0] tg;
        idx = a[6:4];
        tg  = a[9:7];
        hit = ref_valid[idx] && (ref_tag[idx] == tg);
        if (!hit) begin
            ref_valid[idx] = 1'b1;
            ref_tag[idx]   = tg;
        end
    endtask

    function automatic logic [31:0] exp_word(input logic [31:0] a);
        return {24'h0, a[9:2]};
    endfunction

    // Apply one fetch starting at a negedge; returns at the following negedge
    // after the cycle in which busywait was seen low.
    task automatic fetch(input logic [31:0] a, output int bw, output int rd,
                         output logic [5:0] maddr, output logic [31:0] ins);
        address = a;
        bw = 0;
        rd = 0;
        maddr = 6'h3f;
        #1;
        while (busywait && bw < 200) begin
            if (mem_read) begin
                rd++;
                maddr = mem_address;
            end
            bw++;
            @(negedge clk);
            #1;
        end
        ins = instruction;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        n_vec++;
        if (busywait !== 1'b0) begin
            n_err++; $display("FAIL reset_busywait: got %b want 0", busywait);
        end
        n_vec++;
        if (instruction !== 32'd0) begin
            n_err++; $display("FAIL reset_instr: got %h want 0", instruction);
        end
        @(negedge clk);
        #1;
        n_vec++;
        if (mem_read !== 1'b0 || mem_address !== 6'd0) begin
            n_err++; $display("FAIL reset_mem: got rd=%b addr=%h want 0/0", mem_read, mem_address);
        end
        @(negedge clk);
        reset = 1'b0;
        model_clear();
    endtask

    task automatic test_cold_miss();
        int bw, rd; logic [5:0] ma; logic [31:0] ins; bit h;
        mem_lat = 5;
        model_access(32'h000, h);
        fetch(32'h000, bw, rd, ma, ins);
        n_vec++;
        if (bw !== 8) begin n_err++; $display("FAIL cold_penalty: got %0d want 8", bw); end
        n_vec++;
        if (rd !== 6 || ma !== 6'd0) begin
            n_err++; $display("FAIL cold_memread: got %0d cycles addr %h want 6 cycles addr 00", rd, ma);
        end
        n_vec++;
        if (ins !== 32'd0) begin n_err++; $display("FAIL cold_instr: got %h want 0", ins); end
    endtask

    task automatic test_same_block();
        int bw, rd; logic [5:0] ma; logic [31:0] ins; bit h;
        for (int i = 1; i < 4; i++) begin
            model_access(32'(i * 4), h);
            fetch(32'(i * 4), bw, rd, ma, ins);
            n_vec++;
            if (bw !== 0 || rd !== 0 || ins !== 32'(i)) begin
                n_err++;
                $display("FAIL same_block_%0d: got bw=%0d rd=%0d ins=%h want 0/0/%h", i, bw, rd, ins, 32'(i));
            end
        end
    endtask

    task automatic test_conflict();
        int bw, rd; logic [5:0] ma; logic [31:0] ins; bit h;
        logic [31:0] seq [4];
        seq[0] = 32'h010; seq[1] = 32'h090; seq[2] = 32'h090; seq[3] = 32'h010;
        mem_lat = 2;
        for (int i = 0; i < 4; i++) begin
            model_access(seq[i], h);
            fetch(seq[i], bw, rd, ma, ins);
            n_vec++;
            if (bw !== (h ? 0 : 5) || ins !== exp_word(seq[i])) begin
                n_err++;
                $display("FAIL conflict_%0d: got bw=%0d ins=%h want bw=%0d ins=%h",
                         i, bw, ins, (h ? 0 : 5), exp_word(seq[i]));
            end
            if (i == 1) begin
                n_vec++;
                if (ma !== 6'h09) begin
                    n_err++; $display("FAIL conflict_maddr: got %h want 09", ma);
                end
            end
        end
    endtask

    task automatic test_sequential();
        int bw, rd; logic [5:0] ma; logic [31:0] ins; bit h;
        int misses = 0;
        logic [31:0] a;
        test_reset();
        mem_lat = 3;
        for (int i = 0; i < 32; i++) begin
            a = 32'(i * 4);
            model_access(a, h);
            fetch(a, bw, rd, ma, ins);
            if (bw != 0) misses++;
            n_vec++;
            if (bw !== (h ? 0 : 6) || ins !== exp_word(a)) begin
                n_err++;
                $display("FAIL seq_%h: got bw=%0d ins=%h want bw=%0d ins=%h", a, bw, ins, (h ? 0 : 6), exp_word(a));
            end
        end
        n_vec++;
        if (misses !== 8) begin n_err++; $display("FAIL seq_misses: got %0d want 8", misses); end
        // Every line now holds tag 0: arbitrary jumps below 0x80 all hit
        for (int i = 0; i < 16; i++) begin
            a = {$urandom} & 32'hFFFF_FC7F;
            model_access(a, h);
            fetch(a, bw, rd, ma, ins);
            n_vec++;
            if (bw !== 0 || ins !== exp_word(a)) begin
                n_err++; $display("FAIL back_to_back_%h: got bw=%0d ins=%h want 0 ins=%h", a, bw, ins, exp_word(a));
            end
        end
    endtask

    task automatic test_reset_mid();
        int bw, rd; logic [5:0] ma; logic [31:0] ins; bit h;
        mem_lat = 5;
        address = 32'h200;
        @(negedge clk); #1;
        n_vec++;
        if (mem_read !== 1'b1) begin n_err++; $display("FAIL rmid_read: got %b want 1", mem_read); end
        @(negedge clk);
        reset = 1'b1;
        #1;
        n_vec++;
        if (busywait !== 1'b0 || instruction !== 32'd0) begin
            n_err++; $display("FAIL rmid_outs: got bw=%b ins=%h want 0/0", busywait, instruction);
        end
        @(negedge clk); #1;
        n_vec++;
        if (mem_read !== 1'b0) begin n_err++; $display("FAIL rmid_abort: got %b want 0", mem_read); end
        @(negedge clk);
        reset = 1'b0;
        model_clear();
        model_access(32'h200, h);
        fetch(32'h200, bw, rd, ma, ins);
        n_vec++;
        if (bw !== 8 || ins !== exp_word(32'h200)) begin
            n_err++; $display("FAIL rmid_refetch: got bw=%0d ins=%h want 8 ins=%h", bw, ins, exp_word(32'h200));
        end
        model_access(32'h004, h);
        fetch(32'h004, bw, rd, ma, ins);
        n_vec++;
        if (bw !== (h ? 0 : 8)) begin n_err++; $display("FAIL rmid_invalid: got bw=%0d want 8", bw); end
    endtask

    task automatic test_zero_latency();
        int bw, rd; logic [5:0] ma; logic [31:0] ins; bit h;
        mem_lat = 0;
        model_access(32'h3F8, h);
        fetch(32'h3F8, bw, rd, ma, ins);
        n_vec++;
        if (bw !== 3 || rd !== 1 || ins !== exp_word(32'h3F8)) begin
            n_err++; $display("FAIL zero_lat: got bw=%0d rd=%0d ins=%h want 3/1/%h", bw, rd, ins, exp_word(32'h3F8));
        end
    endtask

    task automatic test_random();
        int bw, rd; logic [5:0] ma; logic [31:0] ins; bit h;
        logic [31:0] a;
        for (int i = 0; i < 150; i++) begin
            a = $urandom;
            a[9:7] = 3'($urandom_range(0, 3));
            mem_lat = $urandom_range(0, 4);
            model_access(a, h);
            fetch(a, bw, rd, ma, ins);
            n_vec++;
            if (bw !== (h ? 0 : mem_lat + 3) || ins !== exp_word(a) || (!h && ma !== a[9:4])) begin
                n_err++;
                $display("FAIL random_%0d addr=%h: got bw=%0d ins=%h ma=%h want bw=%0d ins=%h ma=%h",
                         i, a, bw, ins, ma, (h ? 0 : mem_lat + 3), exp_word(a), a[9:4]);
            end
        end
    endtask

    initial begin
        reset        = 1'b1;
        address      = 32'd0;
        mem_busywait = 1'b0;
        mem_readdata = '0;
        model_clear();
        @(negedge clk);
        test_reset();
        test_cold_miss();
        test_same_block();
        test_conflict();
        test_sequential();
        test_reset_mid();
        test_zero_latency();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/icache_ctrl.md
Name: icache_ctrl

Overview:
- Direct-mapped instruction cache between the CPU's PC output and the slow instruction memory.
- The CPU drives the PC as the fetch address. The cache returns a 32-bit instruction and raises busywait on a miss; the CPU stalls PC update while busywait is high.
- On a miss the cache fetches a whole 128-bit block (4 instructions) from instruction memory through a read/busywait handshake.

Parameters:
- NUM_BLOCKS, 8, number of cache lines (power of 2); sets index width IDX_W = log2(NUM_BLOCKS) = 3.
- ADDR_W, 10, low PC bits the cache decodes (1 KB instruction space); tag width = ADDR_W-4-IDX_W = 3.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- address  in  32  fetch address (PC); only bits [ADDR_W-1:2] used, bits [1:0] ignored.
- instruction  out  32  fetched instruction word, valid when busywait=0.
- busywait  out  1  high = instruction not yet available, CPU must stall.
- mem_read  out  1  read request to instruction memory.
- mem_address  out  ADDR_W-4 (6)  block address = address[ADDR_W-1:4].
- mem_readdata  in  128  block from memory; word0 in [31:0] … word3 in [127:96].
- mem_busywait  in  1  memory busy; data valid in the cycle it is sampled low while mem_read=1.

Behaviour:
- Reset: reset and clock are as already decided — synchronous, active-high `reset`; clock `clk`.
- Reset effects (all take effect at the clock edge where reset=1):
  - All valid bits cleared.
  - FSM goes to IDLE.
  - mem_read=0, mem_address=0.
- While reset=1, busywait=0 and instruction=0.
- Address split: word offset = address[3:2], index = address[6:4], tag = address[9:7].
- Storage per line: valid (1b), tag (3b), data (128b).
- hit = valid[index] && tag[index]==address tag. Evaluated combinationally from the current address.
- FSM states:
  - IDLE:
    - busywait = !hit. On a hit, instruction = data[index] word selected by offset, available in the same cycle (zero-wait).
    - On a miss: busywait=1, instruction=0, next edge → MEM_READ.
  - MEM_READ:
    - mem_read=1, mem_address=address[9:4], busywait=1.
    - Stays while mem_busywait=1.
    - On an edge with mem_busywait=0 → UPDATE; mem_readdata is captured into a staging register on that edge.
  - UPDATE (exactly 1 cycle):
    - mem_read=0, busywait=1.
    - On the edge: write staged data into data[index], set tag[index] and valid[index]=1, then → IDLE.
  - IDLE after UPDATE: the hit is recomputed, so busywait drops in the first IDLE cycle.
- Miss penalty: 1 (detect) + N memory busy cycles + 1 (capture) + 1 (UPDATE) before busywait falls.
- The CPU holds address constant while busywait=1. If the address changes mid-fetch, the fill still completes to the index/tag latched at miss detection. The address is registered on IDLE→MEM_READ and mem_address uses the latched value.
- Refill of an occupied line overwrites it unconditionally. There are no writes from the CPU, so there is no dirty state.
- Reset mid-fetch (MEM_READ or UPDATE):
  - Abort; mem_read=0 from the following cycle.
  - No line is written; all lines are invalid.
  - A late mem_readdata is ignored.
- mem_readdata is ignored in every state except MEM_READ with mem_busywait=0.
- Hits in back-to-back cycles, including an index change every cycle: busywait stays 0 throughout.
- Address above ADDR_W bits is ignored (aliases).

Test Plan:
- Cold miss:
  - Stimulus: reset 2 cycles, address=0x000. Memory busy 5 cycles, then returns block 0x00000003_00000002_00000001_00000000.
  - Required: busywait=1 immediately; mem_read=1 with mem_address=0 for 6 cycles; busywait=0 after UPDATE with instruction=0x00000000.
- Same-block hits:
  - Stimulus: after the cold miss, address=0x004, 0x008, 0x00C in consecutive cycles.
  - Required: busywait=0 each cycle; instruction=1, 2, 3; mem_read stays 0.
- Conflict eviction:
  - Stimulus: fill 0x010 (index1, tag0), then access 0x090 (index1, tag1).
  - Required: miss with mem_address=0x09. Afterwards 0x090 hits and 0x010 misses again.
- Sequential fetch across blocks:
  - Stimulus: addresses 0x000…0x07C with memory latency 3.
  - Required: exactly 8 misses, one per block; every instruction value matches the memory model.
- Reset during MEM_READ:
  - Stimulus: assert reset in the 2nd busy cycle, then deassert.
  - Required: mem_read=0 next cycle; the original address misses again afterwards.
- Zero-latency memory:
  - Stimulus: mem_busywait=0 throughout.
  - Required: miss penalty is exactly 3 cycles from busywait rise to fall.
